// File: rtl/spi_xfer_pkg.sv
// Shared constants for the SPI block-transfer controller: register map,
// control/status bit positions, FSM encoding and the idle fill byte.
package spi_xfer_pkg;
    localparam logic [2:0] A_DATA = 3'd0;
    localparam logic [2:0] A_CTRL = 3'd1;
    localparam logic [2:0] A_CNTH = 3'd2;
    localparam logic [2:0] A_CNTL = 3'd3;

    localparam int C_START = 7;
    localparam int C_FLUSH = 6;
    localparam int C_TXW   = 2;
    localparam int C_RXDIS = 1;
    localparam int C_IRQEN = 0;

    localparam int S_BSY   = 7;
    localparam int S_DONE  = 6;
    localparam int S_RXE   = 5;
    localparam int S_RXF   = 4;
    localparam int S_TXE   = 3;
    localparam int S_TXF   = 2;
    localparam int S_IRQEN = 0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_STORE = 2'd3;

    localparam logic [7:0] FILL_BYTE = 8'hFF;

    typedef logic [9:0] cnt_t;
endpackage

// File: rtl/spi_block_xfer_if.sv
// CPU register bus plus SPI byte-engine handshake of the block-transfer controller.
interface spi_block_xfer_if;
    logic [2:0] AD;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       rw;
    logic       cs;
    logic       irq;
    logic       spi_start;
    logic [7:0] spi_tx;
    logic       spi_ready;
    logic       spi_done;
    logic [7:0] spi_rx;

    modport slave  (input  AD, DI, rw, cs, spi_ready, spi_done, spi_rx,
                    output DO, irq, spi_start, spi_tx);
    modport master (output AD, DI, rw, cs, spi_ready, spi_done, spi_rx,
                    input  DO, irq, spi_start, spi_tx);
endinterface

// File: rtl/spi_block_xfer_sync_fifo.sv
// Single-clock FIFO with show-ahead output; overflow/underflow requests are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, rptr_q;
    logic             do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst || clr_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/spi_block_xfer.sv
// CPU-mapped SPI block transfer: streams a counted run of bytes from a TX FIFO
// through an external byte engine, collecting replies in an RX FIFO.
module spi_block_xfer
    import spi_xfer_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input logic              clk,
    input logic              rst,
    spi_block_xfer_if.slave  bus
);
    logic       cs_q;
    logic [7:0] do_q;
    cnt_t       count_q;
    cnt_t       wcnt_q, wcnt_d;
    logic [1:0] state_q, state_d;
    logic       done_q, done_d;
    logic       txw_q, rxdis_q, irqen_q;
    logic       spi_start_q, spi_start_d;
    logic [7:0] spi_tx_q, spi_tx_d;
    logic [7:0] rxb_q, rxb_d;

    logic       acc, rd_acc, wr_acc, ctrl_wr, start, flush, busy;
    logic       tx_push, tx_pop, tx_empty, tx_full;
    logic       rx_push, rx_pop, rx_pop_eff, rx_empty, rx_full;
    logic [7:0] tx_dout, rx_dout, stat, rd_data;

    // Each cs assertion is one access, taken on its first clock.
    assign acc        = bus.cs && !cs_q;
    assign rd_acc     = acc && bus.rw;
    assign wr_acc     = acc && !bus.rw;
    assign ctrl_wr    = wr_acc && (bus.AD == A_CTRL);
    assign start      = ctrl_wr && bus.DI[C_START];
    assign flush      = ctrl_wr && bus.DI[C_FLUSH];
    assign busy       = (state_q != ST_IDLE);
    assign tx_push    = wr_acc && (bus.AD == A_DATA) && !tx_full;
    assign rx_pop     = rd_acc && (bus.AD == A_DATA);
    assign rx_pop_eff = rx_pop && !rx_empty;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .clr_i(flush), .push_i(tx_push), .din_i(bus.DI),
        .pop_i(tx_pop), .dout_o(tx_dout), .empty_o(tx_empty), .full_o(tx_full)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .clr_i(flush), .push_i(rx_push), .din_i(rxb_q),
        .pop_i(rx_pop), .dout_o(rx_dout), .empty_o(rx_empty), .full_o(rx_full)
    );

    always_comb begin
        stat          = '0;
        stat[S_BSY]   = busy;
        stat[S_DONE]  = done_q;
        stat[S_RXE]   = rx_empty;
        stat[S_RXF]   = rx_full;
        stat[S_TXE]   = tx_empty;
        stat[S_TXF]   = tx_full;
        stat[S_IRQEN] = irqen_q;
    end

    always_comb begin
        case (bus.AD)
            A_DATA:  rd_data = rx_empty ? FILL_BYTE : rx_dout;
            A_CTRL:  rd_data = stat;
            A_CNTH:  rd_data = {6'b0, count_q[9:8]};
            A_CNTL:  rd_data = count_q[7:0];
            default: rd_data = 8'h00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        done_d      = done_q;
        spi_start_d = 1'b0;
        spi_tx_d    = spi_tx_q;
        rxb_d       = rxb_q;
        tx_pop      = 1'b0;
        rx_push     = 1'b0;
        if (rd_acc && (bus.AD == A_CTRL)) done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (count_q == '0) begin
                        done_d = 1'b1;
                    end else begin
                        done_d  = 1'b0;
                        wcnt_d  = count_q;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (bus.spi_ready && (!tx_empty || !txw_q)) begin
                    spi_start_d = 1'b1;
                    spi_tx_d    = tx_empty ? FILL_BYTE : tx_dout;
                    tx_pop      = !tx_empty;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.spi_done) begin
                    rxb_d   = bus.spi_rx;
                    state_d = ST_STORE;
                end
            end
            default: begin
                // A CPU pop in this cycle makes room, so the captured byte can go in now.
                if (rxdis_q || !rx_full || rx_pop_eff) begin
                    rx_push = !rxdis_q;
                    wcnt_d  = wcnt_q - 10'd1;
                    if (wcnt_q == 10'd1) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
        endcase
        if (flush) begin
            state_d     = ST_IDLE;
            done_d      = 1'b0;
            spi_start_d = 1'b0;
            tx_pop      = 1'b0;
            rx_push     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cs_q        <= 1'b0;
            do_q        <= 8'h00;
            count_q     <= '0;
            wcnt_q      <= '0;
            state_q     <= ST_IDLE;
            done_q      <= 1'b0;
            txw_q       <= 1'b0;
            rxdis_q     <= 1'b0;
            irqen_q     <= 1'b0;
            spi_start_q <= 1'b0;
            spi_tx_q    <= FILL_BYTE;
            rxb_q       <= 8'h00;
        end else begin
            cs_q        <= bus.cs;
            wcnt_q      <= wcnt_d;
            state_q     <= state_d;
            done_q      <= done_d;
            spi_start_q <= spi_start_d;
            spi_tx_q    <= spi_tx_d;
            rxb_q       <= rxb_d;
            if (rd_acc) do_q <= rd_data;
            if (ctrl_wr) begin
                txw_q   <= bus.DI[C_TXW];
                rxdis_q <= bus.DI[C_RXDIS];
                irqen_q <= bus.DI[C_IRQEN];
            end
            if (wr_acc && !busy) begin
                if (bus.AD == A_CNTH) count_q[9:8] <= bus.DI[1:0];
                if (bus.AD == A_CNTL) count_q[7:0] <= bus.DI;
            end
        end
    end

    assign bus.DO        = do_q;
    assign bus.irq       = done_q && irqen_q;
    assign bus.spi_start = spi_start_q;
    assign bus.spi_tx    = spi_tx_q;
endmodule

// File: doc/spi_block_xfer.md
SPI_BLOCK_XFER -- requirements
Module: spi_block_xfer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning entries per TX and RX FIFO (power of two, 4..64).
REQ-002 SHALL have port clk  in  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  in  1  reset: synchronous, active-low.
REQ-004 SHALL have port AD  in  3  CPU register address.
REQ-005 SHALL have port DI  in  8  CPU write data.
REQ-006 SHALL have port DO  out  8  CPU read data, registered.
REQ-007 SHALL have port rw  in  1  1=read, 0=write.
REQ-008 SHALL have port cs  in  1  block select.
REQ-009 SHALL have port irq  out  1  transfer-complete interrupt, level, active-high.
REQ-010 SHALL have port spi_start  out  1  one-cycle request to the SPI byte engine.
REQ-011 SHALL have port spi_tx  out  8  byte to shift; stable from spi_start until spi_done.
REQ-012 SHALL have port spi_ready  in  1  SPI engine idle, may accept spi_start.
REQ-013 SHALL have port spi_done  in  1  one-cycle pulse; spi_rx valid.
REQ-014 SHALL have port spi_rx  in  8  received byte.

Function
REQ-015 SHALL map registers: $0 W push TX FIFO / R pop RX FIFO; $1 W control / R status; $2 RW count[9:8] in bits 1:0; $3 RW count[7:0]; $4..$7 read 0, writes ignored.
REQ-016 SHALL decode control as bit7 START, bit6 FLUSH, bit2 TXW, bit1 RXDIS, bit0 IRQEN; only TXW, RXDIS and IRQEN are stored.
REQ-017 SHALL return status as BSY|DONE|RXE|RXF|TXE|TXF|0|IRQEN.
REQ-018 SHALL act on each access once, on the first clk of a cs assertion (edge-detected select); the access is held until cs drops.
REQ-019 SHALL load DO one clk after the access edge; a read of $0 pops at the same clk, and an empty RX FIFO returns $FF with no pop.
REQ-020 SHALL drop TX pushes when TXF=1 and RX pushes are never dropped (see REQ-024).
REQ-021 SHALL use FSM states IDLE, ISSUE, WAIT, STORE.
REQ-022 SHALL leave IDLE to ISSUE on START when count != 0 and BSY=0; it SHALL clear DONE, set BSY, and copy count to a working counter; START with count == 0 SHALL set DONE only.
REQ-023 SHALL in ISSUE assert spi_start for one clk once spi_ready=1 and then enter WAIT; spi_tx SHALL be the popped TX byte, or $FF if TX is empty and TXW=0; with TX empty and TXW=1 the FSM SHALL stall in ISSUE.
REQ-024 SHALL in WAIT capture spi_rx on spi_done and enter STORE; STORE SHALL push to RX unless RXDIS=1, stall while RXF=1, then decrement the counter.
REQ-025 SHALL go from STORE to IDLE when the counter reaches 0, setting DONE and clearing BSY; otherwise it SHALL return to ISSUE.
REQ-026 SHALL drive irq = DONE & IRQEN; a status read or START SHALL clear DONE.
REQ-027 SHALL on FLUSH empty both FIFOs and abort: FSM to IDLE, BSY=0, DONE=0; an in-flight spi_done is ignored; if START and FLUSH are written together, FLUSH wins.
REQ-028 SHALL ignore count writes while BSY=1.
REQ-029 SHALL give precedence to a CPU pop over an FSM push in the same clk; both SHALL occur.

Reset
REQ-030 SHALL on rst=0 at a clk edge set: FSM IDLE, FIFOs empty, count=0, TXW=RXDIS=IRQEN=0, BSY=DONE=0, DO=$00, irq=0, spi_start=0, spi_tx=$FF.
REQ-031 SHALL abort any transfer on reset mid-operation, issuing no further spi_start.

Structure
REQ-032 SHALL place the register addresses, control/status bit indices, FSM state encoding and the $FF fill value in shared package spi_xfer_pkg.
REQ-033 SHALL instantiate one sub-module, sync_fifo (8-bit, FIFO_DEPTH), twice for TX and RX.

Verification
REQ-034 Push $40,$00,$00,$00,$00,$95, count=6, START -> six spi_start in order; RX holds six engine bytes; DONE=1; irq=1 with IRQEN.
REQ-035 TX empty, TXW=0, count=512 -> 512 bytes of $FF; with RX never read, the FSM stalls at RXF with no byte lost.
REQ-036 TXW=1, count=2, one byte pushed -> one spi_start, then stall; pushing a second byte resumes; DONE after 2.
REQ-037 FLUSH mid-transfer at byte 3 of 10 -> BSY=0 next clk, FIFOs empty, late spi_done ignored, no more spi_start.
REQ-038 START with count=0 -> DONE=1, no spi_start; count write while BSY=1 -> readback unchanged.
REQ-039 Read $0 with RX empty -> $FF, RXE stays 1; cs held 5 clks on $0 read -> exactly one pop.
